// File: rtl/wb_line_master.sv
// wb_line_master: turns single-word 32-bit CPU loads/stores into 128-bit
// Wishbone classic cycles, with a one-line read buffer and an ack timeout.
module wb_line_master #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk_36m,
  input  logic         rst_n,
  input  logic         init_cpl,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  output logic         wb_we_o,
  output logic [31:0]  wb_adr_o,
  output logic [15:0]  wb_sel_o,
  output logic [127:0] wb_dat_o,
  input  logic [127:0] wb_dat_i,
  input  logic         wb_ack_i
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TAG_W = 28;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state;
  logic [1:0]         lane;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid;
  logic [127:0]       line;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               hit_c;
  logic               unused_c;

  // Word offset bits never reach the bus; the whole line is transferred.
  assign unused_c  = ^req_addr[1:0];

  // Accept only when idle and the DDR side is calibrated.
  assign req_ready = (state == IDLE) && init_cpl;

  // Buffer hit for the incoming request's line.
  assign hit_c     = line_valid && (line_tag == req_addr[31:4]);

  // Extract one 32-bit word of a 128-bit line.
  function automatic logic [31:0] pick_word(input logic [127:0] d, input logic [1:0] l);
    case (l)
      2'd0:    pick_word = d[31:0];
      2'd1:    pick_word = d[63:32];
      2'd2:    pick_word = d[95:64];
      default: pick_word = d[127:96];
    endcase
  endfunction

  // Request FSM, bus master registers and line buffer.
  always_ff @(posedge clk_36m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= 2'd0;
      line_tag   <= '0;
      line_valid <= 1'b0;
      line       <= '0;
      tmo_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lane     <= req_addr[3:2];
            wb_adr_o <= {req_addr[31:4], 4'b0000};
            if (!req_we && hit_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= pick_word(line, req_addr[3:2]);
            end else begin
              state    <= BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= req_we;
              tmo_cnt  <= '0;
              if (req_we) begin
                wb_sel_o <= 16'(req_be) << {req_addr[3:2], 2'b00};
                wb_dat_o <= {4{req_wdata}};
              end else begin
                wb_sel_o <= 16'hFFFF;
                wb_dat_o <= '0;
              end
            end
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            if (!wb_we_o) begin
              line       <= wb_dat_i;
              line_tag   <= wb_adr_o[31:4];
              line_valid <= 1'b1;
              rsp_rdata  <= pick_word(wb_dat_i, lane);
            end else begin
              rsp_rdata <= '0;
              // Write-through: keep a buffered copy of the line coherent.
              if (line_valid && (line_tag == wb_adr_o[31:4])) begin
                for (int i = 0; i < 16; i++) begin
                  if (wb_sel_o[i]) line[8*i +: 8] <= wb_dat_o[8*i +: 8];
                end
              end
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            line_valid <= 1'b0;
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
      // Buffer contents are meaningless until calibration completes.
      if (!init_cpl) line_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_line_master.sv
// Directed bench for wb_line_master with a TIMEOUT of 8 cycles.
module tb_wb_line_master;

  logic         clk_36m = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_cpl = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_be = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]  wb_adr_o;
  logic [15:0]  wb_sel_o;
  logic [127:0] wb_dat_o;
  logic [127:0] wb_dat_i = '0;
  logic         wb_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

  wb_line_master #(.TIMEOUT(8)) dut (
    .clk_36m(clk_36m), .rst_n(rst_n), .init_cpl(init_cpl),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_36m = ~clk_36m;

  task automatic tick();
    @(posedge clk_36m);
    #1;
  endtask

  // Present one request for a single edge (caller ensures req_ready).
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_cpl = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2000;
    #12;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_bus: got cyc=%b stb=%b we=%b want 0", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (wb_adr_o !== 32'h0 || wb_sel_o !== 16'h0 || wb_dat_o !== 128'h0) begin errors++; $display("FAIL rst_regs: got adr=%h sel=%h dat=%h want 0", wb_adr_o, wb_sel_o, wb_dat_o); end
    @(negedge clk_36m); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_ready !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL noinit_%0d: got ready=%b cyc=%b want 0 0", i, req_ready, wb_cyc_o); end
    end
    init_cpl = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", req_ready); end
    tick(); req_valid = 1'b0;
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL init_accept: got cyc=%b want 1", wb_cyc_o); end
    wb_ack_i = 1'b1; wb_dat_i = '0; tick(); wb_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL init_rsp: got %b want 1", rsp_valid); end
    tick();
  endtask

  task automatic test_miss_hit();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL miss_ready: got %b want 1", req_ready); end
    issue(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++; $display("FAIL miss_cyc: got cyc=%b we=%b want 1 0", wb_cyc_o, wb_we_o); end
    checks++; if (wb_adr_o !== 32'h0000_1000) begin errors++; $display("FAIL miss_adr: got %h want 00001000", wb_adr_o); end
    checks++; if (wb_sel_o !== 16'hFFFF) begin errors++; $display("FAIL miss_sel: got %h want ffff", wb_sel_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_stb_o !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL miss_wait_%0d: got stb=%b rv=%b want 1 0", i, wb_stb_o, rsp_valid); end
      tick();
    end
    wb_ack_i = 1'b1; wb_dat_i = LINE_A; tick(); wb_ack_i = 1'b0;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL miss_drop: got cyc=%b stb=%b want 0", wb_cyc_o, wb_stb_o); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h3333_3333) begin errors++; $display("FAIL miss_rsp: got v=%b e=%b d=%h want 1 0 33333333", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL miss_pulse: got %b want 0", rsp_valid); end
    issue(1'b0, 32'h0000_100C, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h4444_4444 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL hit_rsp: got v=%b d=%h cyc=%b want 1 44444444 0", rsp_valid, rsp_rdata, wb_cyc_o); end
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hit_next_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_merge();
    issue(1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011);
    checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_adr_o !== 32'h0000_1000) begin errors++; $display("FAIL st_cyc: got cyc=%b we=%b adr=%h want 1 1 00001000", wb_cyc_o, wb_we_o, wb_adr_o); end
    checks++; if (wb_sel_o !== 16'h0030) begin errors++; $display("FAIL st_sel: got %h want 0030", wb_sel_o); end
    checks++; if (wb_dat_o !== {4{32'hAABB_CCDD}}) begin errors++; $display("FAIL st_dat: got %h want aabbccdd x4", wb_dat_o); end
    tick();
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL st_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2222_CCDD || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL merge_hit: got v=%b d=%h cyc=%b want 1 2222ccdd 0", rsp_valid, rsp_rdata, wb_cyc_o); end
    tick();
    issue(1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000);
    checks++; if (wb_cyc_o !== 1'b1 || wb_sel_o !== 16'h0000) begin errors++; $display("FAIL st_be0: got cyc=%b sel=%h want 1 0000", wb_cyc_o, wb_sel_o); end
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    tick();
    issue(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3333_3333) begin errors++; $display("FAIL be0_hit: got v=%b d=%h want 1 33333333", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_zero_wait();
    issue(1'b0, 32'h0000_3008, 32'h0, 4'h0);
    checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("FAIL zw_stb: got %b want 1", wb_stb_o); end
    wb_ack_i = 1'b1; wb_dat_i = LINE_B; tick(); wb_ack_i = 1'b0;
    checks++; if (wb_stb_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hCCCC_CCCC) begin errors++; $display("FAIL zw_rsp: got stb=%b v=%b d=%h want 0 1 cccccccc", wb_stb_o, rsp_valid, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL zw_after: got v=%b stb=%b want 0 0", rsp_valid, wb_stb_o); end
  endtask

  task automatic test_timeout();
    issue(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 8; i++) begin
      checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("FAIL to_stb_%0d: got %b want 1", i, wb_stb_o); end
      tick();
    end
    checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL to_drop: got stb=%b cyc=%b want 0 0", wb_stb_o, wb_cyc_o); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp: got v=%b e=%b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    issue(1'b0, 32'h0000_3004, 32'h0, 4'h0);
    checks++; if (wb_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_inval: got cyc=%b v=%b want 1 0", wb_cyc_o, rsp_valid); end
    wb_ack_i = 1'b1; wb_dat_i = LINE_B; tick(); wb_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBBBB_BBBB) begin errors++; $display("FAIL to_refill: got v=%b d=%h want 1 bbbbbbbb", rsp_valid, rsp_rdata); end
    tick();
    issue(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("FAIL late_stb: got %b want 1", wb_stb_o); end
    wb_ack_i = 1'b1; wb_dat_i = LINE_A; tick(); wb_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1111_1111) begin errors++; $display("FAIL late_ack: got v=%b e=%b d=%h want 1 0 11111111", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_init_invalidate();
    init_cpl = 1'b0; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL inv_ready: got %b want 0", req_ready); end
    tick();
    init_cpl = 1'b1;
    issue(1'b0, 32'h0000_5004, 32'h0, 4'h0);
    checks++; if (wb_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL inv_miss: got cyc=%b v=%b want 1 0", wb_cyc_o, rsp_valid); end
    wb_ack_i = 1'b1; wb_dat_i = LINE_A; tick(); wb_ack_i = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2222_2222) begin errors++; $display("FAIL inv_rsp: got v=%b d=%h want 1 22222222", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    tick();
    checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("FAIL rm_stb: got %b want 1", wb_stb_o); end
    rst_n = 1'b0; #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL rm_drop: got cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o); end
    @(negedge clk_36m); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rm_after_%0d: got v=%b cyc=%b want 0 0", i, rsp_valid, wb_cyc_o); end
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_store_merge();
    test_zero_wait();
    test_timeout();
    test_init_invalidate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
